ps2_keyboard_rx: RTL and testbench
==================================

# ps2_keyboard_rx

Parametrised PS/2 keyboard receiver that replaces the fake keycode generator. It deserialises real PS2C/PS2D frames and checks parity, stop bit and inter-bit timeout. It folds E0/F0 prefixes into decoded key events and buffers them in a small FIFO with a valid/ready handshake. A raw-byte strobe is kept for existing keycode consumers.

## Interface
- FILTER_LEN, 8: consecutive identical ck samples required before filtered PS2C changes (1..255).
- TIMEOUT_CYCLES, 50000: ck cycles without a filtered PS2C falling edge, mid-frame, before the frame is aborted.
- FIFO_DEPTH, 4: event FIFO entries; power of 2, ≥2.
- ck  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- PS2C  in  1  PS/2 clock from keyboard (asynchronous).
- PS2D  in  1  PS/2 data from keyboard (asynchronous).
- raw_code  out  8  last good byte received.
- raw_valid  out  1  one-cycle pulse when raw_code updates.
- ev_code  out  8  key code at FIFO head.
- ev_ext  out  1  head event was E0-prefixed.
- ev_break  out  1  head event is a release (F0-prefixed).
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer pops the head when ev_valid && ev_ready.
- frame_err  out  1  one-cycle pulse on a parity, stop-bit or timeout error.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full; cleared only by reset.

## Operation
- Input conditioning: PS2C and PS2D each pass through a 2-flop synchroniser. PS2C is then filtered. The filtered value changes only after FILTER_LEN consecutive equal synchronised samples. The filter resets to 1.
- A bit is sampled from synchronised PS2D on the cycle a filtered-PS2C 1→0 transition is detected (`fall`).
- Frame state machine: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 → DATA, bit count 0. On `fall` with data=1 → stay in IDLE, no error.
  - DATA: on each `fall`, shift in LSB first. After the 8th bit → PARITY.
  - PARITY: on `fall`, capture the bit → STOP.
  - STOP: on `fall` → IDLE. The byte is good if the 8 data bits plus the parity bit have odd weight and the stop bit is 1. Otherwise pulse frame_err, discard the byte, and clear the prefix flags.
- Timeout: a cycle counter resets on every `fall` and runs only outside IDLE. When it reaches TIMEOUT_CYCLES: go to IDLE, pulse frame_err, clear the prefix flags, keep no partial data.
- Byte decode for a good byte:
  - raw_code is updated and raw_valid pulses for every good byte.
  - E0 sets ext. F0 sets brk. Neither pushes an event.
  - E1, AA, FA, EE, FE, 00 and FF push no event and clear both flags.
  - Any other byte pushes {ext, brk, byte} and clears both flags.
- FIFO:
  - Synchronous, FIFO_DEPTH entries, no fall-through.
  - ev_* outputs are driven from the head entry. Storage resets to 0, so the fields read 0 while empty after reset.
  - Push while full and not popping: the event is dropped and overflow is set.
  - Push and pop in the same cycle while full: both occur, count unchanged.
  - Push and pop in the same cycle while empty: not possible, since the pop requires ev_valid.
- Reset mid-frame: the state machine goes to IDLE. Counters, flags, FIFO pointers and storage are cleared.

## Timing
- Reset values: raw_code=0, raw_valid=0, ev_code=0, ev_ext=0, ev_break=0, ev_valid=0, frame_err=0, overflow=0.
- Input latency: a PS2C pin edge reaches `fall` after 2 synchroniser cycles plus FILTER_LEN cycles.
- Let cycle N be the cycle `fall` is detected for the stop bit.
  - raw_valid or frame_err is high in cycle N+1.
  - The event is pushed at the end of N+1. ev_valid is high from N+2 if the FIFO was empty.
- Pop: on the edge where ev_valid && ev_ready, the head advances. ev_valid drops the next cycle if that was the last entry.
- Pulses are exactly one ck cycle wide. raw_valid and frame_err never coincide.

## Test plan
Bench settings: FILTER_LEN=4, TIMEOUT_CYCLES=2000, PS2C half-period 20 ck, ev_ready=1 unless stated.

1. Frame 0x16 with correct parity → raw_code=0x16 and one raw_valid pulse. One event {ext=0, brk=0, code=0x16}, ev_valid at stop-fall+2.
2. Sequence E0 F0 75 → raw_valid pulses three times. Exactly one event {ext=1, brk=1, code=0x75}. Flags are clear afterwards: a following 0x1C gives {0, 0, 0x1C}.
3. Frame 0x1C with parity flipped, then a good 0x1C → one frame_err pulse, no raw_valid for the first frame, one event for the second frame only.
4. Stop PS2C after 4 data bits for 2100 ck, then send a good 0x29 → frame_err asserts exactly 2000 ck after the last `fall`. Then one event {0, 0, 0x29}.
5. ev_ready=0, FIFO_DEPTH=4, send 5 make codes 0x15, 0x1D, 0x24, 0x2D, 0x2C → 4 events held, overflow=1. Releasing ev_ready pops 0x15, 0x1D, 0x24, 0x2D in order.
6. Assert reset_n=0 for 1 cycle mid-DATA, then send a good 0x16 → all outputs return to their reset values. The next frame decodes cleanly with no frame_err.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and filters PS2C/PS2D, deserialises
// 11-bit frames, folds E0/F0 prefixes into key events and queues them in a FIFO.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       ck,
  input  logic       reset_n,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic [7:0] raw_code,
  output logic       raw_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       frame_err,
  output logic       overflow,
  output logic [1:0] dbg_state
);
  // Handshake: an event transfers on every ck edge where ev_valid && ev_ready;
  // ev_valid stays high while the FIFO holds data, independent of ev_ready.

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0] c_sync, d_sync;
  logic       c_filt;
  logic [7:0] filt_cnt;
  logic       fall, d_bit;

  always_ff @(posedge ck) begin
    if (!reset_n) begin
      c_sync   <= 2'b11;
      d_sync   <= 2'b11;
      c_filt   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      c_sync <= {c_sync[0], PS2C};
      d_sync <= {d_sync[0], PS2D};
      if (c_sync[1] == c_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == 8'(FILTER_LEN - 1)) begin
        c_filt   <= c_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 8'd1;
      end
    end
  end

  // High in the cycle before the filtered clock commits its 1->0 change.
  assign fall  = c_filt && !c_sync[1] && (filt_cnt == 8'(FILTER_LEN - 1));
  assign d_bit = d_sync[1];

  state_t          state, state_d;
  logic [2:0]      bit_cnt, bit_cnt_d;
  logic [7:0]      shift, shift_d;
  logic            par, par_d;
  logic [TW-1:0]   to_cnt, to_cnt_d;
  logic            good, bad, timeout;

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    par_d     = par;
    good      = 1'b0;
    bad       = 1'b0;
    timeout   = 1'b0;
    if (state == S_IDLE || fall) to_cnt_d = '0;
    else                         to_cnt_d = to_cnt + 1'b1;
    case (state)
      S_IDLE: if (fall && !d_bit) begin
        state_d   = S_DATA;
        bit_cnt_d = 3'd0;
      end
      S_DATA: if (fall) begin
        shift_d   = {d_bit, shift[7:1]};
        bit_cnt_d = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_d = S_PARITY;
      end
      S_PARITY: if (fall) begin
        par_d   = d_bit;
        state_d = S_STOP;
      end
      S_STOP: if (fall) begin
        state_d = S_IDLE;
        if (d_bit && (^{shift, par})) good = 1'b1;
        else                          bad  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state != S_IDLE && !fall && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d  = S_IDLE;
      timeout  = 1'b1;
      shift_d  = '0;
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge ck) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par       <= 1'b0;
      to_cnt    <= '0;
      raw_code  <= '0;
      raw_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      shift     <= shift_d;
      par       <= par_d;
      to_cnt    <= to_cnt_d;
      raw_valid <= good;
      frame_err <= bad | timeout;
      if (good) raw_code <= shift;
    end
  end

  assign dbg_state = state;

  // Prefix decode runs one cycle after the stop bit, on the registered byte.
  logic ext, brk, ext_d, brk_d, push;

  always_comb begin
    ext_d = ext;
    brk_d = brk;
    push  = 1'b0;
    if (frame_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (raw_valid) begin
      case (raw_code)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
        default: begin
          push  = 1'b1;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end
  end

  logic [10:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, pop, do_write;

  assign ev_valid = (wr_ptr != rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = ev_valid && ev_ready;
  assign do_write = push && (!full || pop);

  always_ff @(posedge ck) begin
    if (!reset_n) begin
      ext      <= 1'b0;
      brk      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      ext <= ext_d;
      brk <= brk_d;
      if (do_write) begin
        mem[wr_ptr[AW-1:0]] <= {ext, brk, raw_code};
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign {ev_ext, ev_break, ev_code} = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: drives PS/2 frames on the pins and checks raw bytes,
// errors and key events against a byte-level reference model.
module tb_ps2_keyboard_rx;
  localparam int F     = 4;
  localparam int TO    = 2000;
  localparam int DEPTH = 4;
  localparam int HALF  = 20;

  logic       ck = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       ev_ready = 1'b1;
  logic [7:0] raw_code, ev_code;
  logic       raw_valid, ev_ext, ev_break, ev_valid, frame_err, overflow;
  logic [1:0] dbg_state;

  ps2_keyboard_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
    .ck(ck), .reset_n(reset_n), .PS2C(ps2c), .PS2D(ps2d),
    .raw_code(raw_code), .raw_valid(raw_valid),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .frame_err(frame_err), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 ck = ~ck;
  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;

  // reference model state
  logic [10:0] exp_q[$];
  logic [7:0]  exp_raw[$];
  bit          m_ext = 0, m_brk = 0;
  int          exp_err = 0, exp_raw_total = 0;

  // observed activity
  int raw_cnt = 0, err_cnt = 0, pop_cnt = 0;
  int raw_cyc = -1, err_cyc = -1, ev_rise_cyc = -1;
  bit ev_valid_q = 0;

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_err++;
      m_ext = 0;
      m_brk = 0;
    end else begin
      exp_raw.push_back(b);
      exp_raw_total++;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        if (!(b inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) &&
            exp_q.size() < DEPTH)
          exp_q.push_back({m_ext, m_brk, b});
        m_ext = 0;
        m_brk = 0;
      end
    end
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge ck) begin
    if (raw_valid) begin
      raw_cnt++;
      raw_cyc = cyc;
      vectors++;
      if (exp_raw.size() == 0) begin
        miscompares++;
        $display("FAIL raw_unexpected got %02h want none", raw_code);
      end else begin
        logic [7:0] e;
        e = exp_raw.pop_front();
        if (raw_code !== e) begin
          miscompares++;
          $display("FAIL raw_code got %02h want %02h", raw_code, e);
        end
      end
    end
    if (frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (raw_valid && frame_err) begin
      vectors++;
      miscompares++;
      $display("FAIL pulse_overlap got raw_valid=1 frame_err=1 want not both");
    end
    if (ev_valid && !ev_valid_q) ev_rise_cyc = cyc;
    ev_valid_q = ev_valid;
    if (ev_valid && ev_ready) begin
      pop_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL event_unexpected got %b/%b/%02h want none", ev_ext, ev_break, ev_code);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        if ({ev_ext, ev_break, ev_code} !== e) begin
          miscompares++;
          $display("FAIL event got %b/%b/%02h want %b/%b/%02h",
                   ev_ext, ev_break, ev_code, e[10], e[9], e[7:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge ck);
    #2;
  endtask

  task automatic clk_bit(input logic d, output int k);
    ps2d = d;
    wait_cyc(HALF / 2);
    ps2c = 1'b0;
    k = cyc;
    wait_cyc(HALF);
    ps2c = 1'b1;
    wait_cyc(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, output int k_stop);
    int k;
    clk_bit(1'b0, k);
    for (int i = 0; i < 8; i++) clk_bit(b[i], k);
    clk_bit((~^b) ^ flip_par, k);
    ps2d = 1'b1;
    wait_cyc(HALF / 2);
    ps2c = 1'b0;
    k_stop = cyc;
    model_byte(b, !flip_par);
    wait_cyc(HALF);
    ps2c = 1'b1;
    wait_cyc(HALF / 2);
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if ({raw_code, raw_valid, ev_code, ev_ext, ev_break, ev_valid, frame_err, overflow} !== 22'd0) begin
      miscompares++;
      $display("FAIL %s got raw=%02h rv=%b ev=%b/%b/%02h evv=%b fe=%b ovf=%b want all 0",
               tag, raw_code, raw_valid, ev_ext, ev_break, ev_code, ev_valid, frame_err, overflow);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    wait_cyc(5);
    check_idle_outputs("reset_values");
    reset_n = 1'b1;
    wait_cyc(5);
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_single;
    int k, r0, p0;
    r0 = raw_cnt; p0 = pop_cnt;
    send_frame(8'h16, 0, k);
    wait_cyc(30);
    vectors++;
    if (raw_cnt - r0 !== 1) begin miscompares++; $display("FAIL single_raw_count got %0d want 1", raw_cnt - r0); end
    vectors++;
    if (raw_code !== 8'h16) begin miscompares++; $display("FAIL single_raw_code got %02h want 16", raw_code); end
    vectors++;
    if (raw_cyc !== k + 2 + F) begin miscompares++; $display("FAIL single_raw_cycle got %0d want %0d", raw_cyc, k + 2 + F); end
    vectors++;
    if (ev_rise_cyc !== k + 3 + F) begin miscompares++; $display("FAIL single_ev_valid_cycle got %0d want %0d", ev_rise_cyc, k + 3 + F); end
    vectors++;
    if (pop_cnt - p0 !== 1) begin miscompares++; $display("FAIL single_event_count got %0d want 1", pop_cnt - p0); end
  endtask

  task automatic test_prefix;
    int k, r0, p0;
    r0 = raw_cnt; p0 = pop_cnt;
    send_frame(8'hE0, 0, k);
    send_frame(8'hF0, 0, k);
    send_frame(8'h75, 0, k);
    wait_cyc(30);
    vectors++;
    if (raw_cnt - r0 !== 3) begin miscompares++; $display("FAIL prefix_raw_count got %0d want 3", raw_cnt - r0); end
    vectors++;
    if (pop_cnt - p0 !== 1) begin miscompares++; $display("FAIL prefix_event_count got %0d want 1", pop_cnt - p0); end
    send_frame(8'h1C, 0, k);
    wait_cyc(30);
    vectors++;
    if (pop_cnt - p0 !== 2) begin miscompares++; $display("FAIL prefix_followup_count got %0d want 2", pop_cnt - p0); end
  endtask

  task automatic test_parity;
    int k, r0, e0, p0;
    r0 = raw_cnt; e0 = err_cnt; p0 = pop_cnt;
    send_frame(8'h1C, 1, k);
    wait_cyc(30);
    vectors++;
    if (err_cyc !== k + 2 + F) begin miscompares++; $display("FAIL parity_err_cycle got %0d want %0d", err_cyc, k + 2 + F); end
    send_frame(8'h1C, 0, k);
    wait_cyc(30);
    vectors++;
    if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL parity_err_count got %0d want 1", err_cnt - e0); end
    vectors++;
    if (raw_cnt - r0 !== 1) begin miscompares++; $display("FAIL parity_raw_count got %0d want 1", raw_cnt - r0); end
    vectors++;
    if (pop_cnt - p0 !== 1) begin miscompares++; $display("FAIL parity_event_count got %0d want 1", pop_cnt - p0); end
  endtask

  task automatic test_timeout;
    int k, k_last, e0, r0, p0;
    logic [7:0] b;
    b = 8'h29;
    e0 = err_cnt; r0 = raw_cnt; p0 = pop_cnt;
    clk_bit(1'b0, k_last);
    for (int i = 0; i < 4; i++) clk_bit(b[i], k_last);
    ps2d = 1'b1;
    model_byte(8'h00, 0);
    wait_cyc(2100);
    vectors++;
    if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL timeout_err_count got %0d want 1", err_cnt - e0); end
    vectors++;
    if (err_cyc !== k_last + 2 + F + TO) begin miscompares++; $display("FAIL timeout_err_cycle got %0d want %0d", err_cyc, k_last + 2 + F + TO); end
    send_frame(8'h29, 0, k);
    wait_cyc(30);
    vectors++;
    if (raw_cnt - r0 !== 1) begin miscompares++; $display("FAIL timeout_raw_count got %0d want 1", raw_cnt - r0); end
    vectors++;
    if (pop_cnt - p0 !== 1) begin miscompares++; $display("FAIL timeout_event_count got %0d want 1", pop_cnt - p0); end
  endtask

  task automatic test_overflow;
    int k, p0;
    logic [7:0] codes [5];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    p0 = pop_cnt;
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(codes[i], 0, k);
    wait_cyc(10);
    vectors++;
    if (pop_cnt - p0 !== 0) begin miscompares++; $display("FAIL overflow_held_pops got %0d want 0", pop_cnt - p0); end
    vectors++;
    if ({ev_valid, ev_code} !== {1'b1, 8'h15}) begin miscompares++; $display("FAIL overflow_head got v=%b %02h want v=1 15", ev_valid, ev_code); end
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL overflow_flag got %b want 1", overflow); end
    ev_ready = 1'b1;
    wait_cyc(10);
    vectors++;
    if (pop_cnt - p0 !== 4) begin miscompares++; $display("FAIL overflow_drain_count got %0d want 4", pop_cnt - p0); end
    vectors++;
    if ({ev_valid, overflow} !== 2'b01) begin miscompares++; $display("FAIL overflow_after_drain got v=%b ovf=%b want v=0 ovf=1", ev_valid, overflow); end
  endtask

  task automatic test_random;
    int k, r;
    logic [7:0] b;
    logic [7:0] ignore_tbl [7];
    ignore_tbl = '{8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    for (int n = 0; n < 16; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3) send_frame(8'hE0, 0, k);
      if (r == 2 || r == 4) send_frame(8'hF0, 0, k);
      b = (r == 9) ? ignore_tbl[$urandom_range(0, 6)] : 8'($urandom_range(0, 255));
      send_frame(b, ($urandom_range(0, 7) == 0), k);
    end
    wait_cyc(30);
    vectors++;
    if (raw_cnt !== exp_raw_total) begin miscompares++; $display("FAIL random_raw_total got %0d want %0d", raw_cnt, exp_raw_total); end
    vectors++;
    if (err_cnt !== exp_err) begin miscompares++; $display("FAIL random_err_total got %0d want %0d", err_cnt, exp_err); end
    vectors++;
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL random_events_missing got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    int k, e0, p0;
    send_frame(8'hE0, 0, k);
    clk_bit(1'b0, k);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, k);
    reset_n = 1'b0;
    wait_cyc(1);
    reset_n = 1'b1;
    m_ext = 0; m_brk = 0;
    exp_q.delete();
    exp_raw.delete();
    wait_cyc(1);
    check_idle_outputs("reset_mid_values");
    wait_cyc(50);
    e0 = err_cnt; p0 = pop_cnt;
    send_frame(8'h16, 0, k);
    wait_cyc(30);
    vectors++;
    if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL reset_mid_err got %0d want 0", err_cnt - e0); end
    vectors++;
    if (pop_cnt - p0 !== 1) begin miscompares++; $display("FAIL reset_mid_event_count got %0d want 1", pop_cnt - p0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_timeout();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
